// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM->WB pipeline register: WB control bit positions,
// skid-buffer state encoding and the entry layout at default widths.
package memwb_pkg;

   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;

   localparam int MEMWB_DATA_W = 64;
   localparam int MEMWB_REG_W  = 5;
   localparam int MEMWB_WB_W   = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [MEMWB_WB_W-1:0]   wb;
      logic [MEMWB_DATA_W-1:0] mem;
      logic [MEMWB_DATA_W-1:0] alu;
      logic [MEMWB_REG_W-1:0]  rd;
   } entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid catches one
// extra entry so in_ready depends only on registered state.
import memwb_pkg::*;

module pipe_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             push, pop;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = (state_q != ST_FULL);
   assign out_data  = main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      push    = in_valid & in_ready;
      pop     = out_valid & out_ready;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            case ({push, pop})
               2'b10: begin
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end
               2'b01: state_d = ST_EMPTY;
               2'b11: main_d = in_data;
               default: state_d = ST_ONE;
            endcase
         end
         ST_FULL: begin
            // skid always drains into main, never straight to the output
            if (pop) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// MEMWB_RESULT_MUX_EN adds a registered OResult (memory data when MemToReg, else ALU).
import memwb_pkg::*;

module mem_wb_pipe_stage #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              IValid,
   output logic              IReady,
   input  logic              IFlush,
   input  logic [WB_W-1:0]   IWB,
   input  logic [DATA_W-1:0] IDataMemory,
   input  logic [DATA_W-1:0] IAlu,
   input  logic [REG_W-1:0]  IInstruction,
   output logic              OValid,
   input  logic              OReady,
   output logic [WB_W-1:0]   OWB,
   output logic [DATA_W-1:0] ODataMemory,
   output logic [DATA_W-1:0] OAlu,
   output logic [REG_W-1:0]  OInstruction
`ifdef MEMWB_RESULT_MUX_EN
   ,
   output logic [DATA_W-1:0] OResult
`endif
);

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [DATA_W-1:0] mem;
      logic [DATA_W-1:0] alu;
      logic [REG_W-1:0]  rd;
   } stage_entry_t;

   localparam int ENTRY_W = $bits(stage_entry_t);
`ifdef MEMWB_RESULT_MUX_EN
   localparam int VEC_W = ENTRY_W + DATA_W;
`else
   localparam int VEC_W = ENTRY_W;
`endif

   stage_entry_t     in_entry, out_entry;
   logic [VEC_W-1:0] in_vec, out_vec;

   always_comb begin
      in_entry.wb  = IWB;
      in_entry.mem = IDataMemory;
      in_entry.alu = IAlu;
      in_entry.rd  = IInstruction;
      // x0 is hardwired zero, so a write to it is dropped at capture
      if (IInstruction == '0) in_entry.wb[WB_REGWRITE] = 1'b0;
`ifdef MEMWB_RESULT_MUX_EN
      in_vec = {in_entry, (IWB[WB_MEMTOREG] ? IDataMemory : IAlu)};
`else
      in_vec = in_entry;
`endif
   end

   pipe_skid_buf #(.WIDTH(VEC_W)) u_skid (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .flush     (IFlush),
      .in_valid  (IValid),
      .in_ready  (IReady),
      .in_data   (in_vec),
      .out_valid (OValid),
      .out_ready (OReady),
      .out_data  (out_vec)
   );

`ifdef MEMWB_RESULT_MUX_EN
   assign out_entry = out_vec[VEC_W-1 -: ENTRY_W];
   assign OResult   = out_vec[DATA_W-1:0];
`else
   assign out_entry = out_vec;
`endif

   assign OWB          = out_entry.wb;
   assign ODataMemory  = out_entry.mem;
   assign OAlu         = out_entry.alu;
   assign OInstruction = out_entry.rd;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Scoreboard bench for mem_wb_pipe_stage: driver queues expected entries on accept,
// monitor pops and compares on every output transfer.
module tb_mem_wb_pipe_stage;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        IValid, IReady, IFlush, OValid, OReady;
   logic [1:0]  IWB, OWB;
   logic [63:0] IDataMemory, IAlu, ODataMemory, OAlu;
   logic [4:0]  IInstruction, OInstruction;
`ifdef MEMWB_RESULT_MUX_EN
   logic [63:0] OResult;
`endif

   typedef struct {
      logic [1:0]  wb;
      logic [63:0] mem;
      logic [63:0] alu;
      logic [4:0]  rd;
      logic [63:0] res;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 Clk = ~Clk;

   mem_wb_pipe_stage dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .IValid       (IValid),
      .IReady       (IReady),
      .IFlush       (IFlush),
      .IWB          (IWB),
      .IDataMemory  (IDataMemory),
      .IAlu         (IAlu),
      .IInstruction (IInstruction),
      .OValid       (OValid),
      .OReady       (OReady),
      .OWB          (OWB),
      .ODataMemory  (ODataMemory),
      .OAlu         (OAlu),
      .OInstruction (OInstruction)
`ifdef MEMWB_RESULT_MUX_EN
      ,
      .OResult      (OResult)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor: pop on every real output transfer (flush cancels the transfer)
   initial begin
      forever begin
         @(negedge Clk);
         #2;
         if (Rst_n === 1'b1 && OValid === 1'b1 && OReady === 1'b1 && IFlush !== 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output actual=OAlu %0h required=no entry", OAlu);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_wb", {62'd0, OWB}, {62'd0, e.wb});
               chk("out_mem", ODataMemory, e.mem);
               chk("out_alu", OAlu, e.alu);
               chk("out_rd", {59'd0, OInstruction}, {59'd0, e.rd});
`ifdef MEMWB_RESULT_MUX_EN
               chk("out_result", OResult, e.res);
`endif
            end
         end
      end
   end

   // drive one entry, retrying while IReady is low; expected values are given by the caller
   task automatic send(input logic [1:0] wb, input logic [63:0] mem, input logic [63:0] alu,
                       input logic [4:0] rd, input logic [1:0] exp_wb, input logic [63:0] exp_res);
      bit done = 0;
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge Clk);
         IValid = 1'b1; IWB = wb; IDataMemory = mem; IAlu = alu; IInstruction = rd;
         #2;
         if (IReady === 1'b1) begin
            exp_t e;
            e.wb = exp_wb; e.mem = mem; e.alu = alu; e.rd = rd; e.res = exp_res;
            sb.push_back(e);
            done = 1;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout actual=IReady %0b required=1", IReady);
      end
   endtask

   task automatic idle();
      @(negedge Clk);
      IValid = 1'b0;
   endtask

   task automatic drain(input int cycles);
      for (int t = 0; t < cycles && sb.size() != 0; t++) @(negedge Clk);
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      Rst_n = 1'b0; IValid = 1'b0; IFlush = 1'b0; OReady = 1'b0;
      IWB = '0; IDataMemory = '0; IAlu = '0; IInstruction = '0;
      repeat (2) @(negedge Clk);
      chk("rst_ovalid", {63'd0, OValid}, 64'd0);
      chk("rst_iready", {63'd0, IReady}, 64'd1);
      chk("rst_owb", {62'd0, OWB}, 64'd0);
      chk("rst_omem", ODataMemory, 64'd0);
      chk("rst_oalu", OAlu, 64'd0);
      chk("rst_ord", {59'd0, OInstruction}, 64'd0);
      Rst_n = 1'b1;

      // streaming at full rate
      OReady = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clk);
         IValid = 1'b1; IWB = 2'b01; IDataMemory = 64'(i) << 4; IAlu = 64'(i); IInstruction = 5'(i);
         #2;
         chk("stream_iready", {63'd0, IReady}, 64'd1);
         if (i > 1) chk("stream_no_bubble", {63'd0, OValid}, 64'd1);
         begin
            exp_t e;
            e.wb = 2'b01; e.mem = 64'(i) << 4; e.alu = 64'(i); e.rd = 5'(i); e.res = 64'(i);
            sb.push_back(e);
         end
      end
      idle();
      #2;
      chk("stream_last_valid", {63'd0, OValid}, 64'd1);
      chk("stream_last_alu", OAlu, 64'd8);
      drain(10);

      // back-pressure: A then B held, released in order
      OReady = 1'b0;
      send(2'b01, 64'h10, 64'hA, 5'd1, 2'b01, 64'hA);
      send(2'b01, 64'h20, 64'hB, 5'd2, 2'b01, 64'hB);
      idle();
      for (int t = 0; t < 3; t++) begin
         #2;
         chk("bp_iready_low", {63'd0, IReady}, 64'd0);
         chk("bp_hold_alu", OAlu, 64'hA);
         chk("bp_hold_valid", {63'd0, OValid}, 64'd1);
         @(negedge Clk);
      end
      OReady = 1'b1;
      drain(10);

      // flush from FULL with a concurrent input
      OReady = 1'b0;
      send(2'b01, 64'h1, 64'hA, 5'd3, 2'b01, 64'hA);
      send(2'b01, 64'h2, 64'hB, 5'd4, 2'b01, 64'hB);
      @(negedge Clk);
      IFlush = 1'b1; IValid = 1'b1; IAlu = 64'hC; IInstruction = 5'd5;
      #2;
      sb.delete();
      @(negedge Clk);
      IFlush = 1'b0; IValid = 1'b0; OReady = 1'b1;
      #2;
      chk("flush_ovalid", {63'd0, OValid}, 64'd0);
      chk("flush_iready", {63'd0, IReady}, 64'd1);
      chk("flush_oalu", OAlu, 64'd0);
      repeat (4) @(negedge Clk);

      // RegWrite squash on x0
      send(2'b11, 64'h55, 64'h66, 5'd0, 2'b10, 64'h55);
      send(2'b11, 64'h55, 64'h66, 5'd5, 2'b11, 64'h55);
      // result mux select (also exercised on the default build via OWB/data)
      send(2'b10, 64'h55, 64'h66, 5'd7, 2'b10, 64'h55);
      send(2'b01, 64'h55, 64'h66, 5'd7, 2'b01, 64'h66);
      idle();
      drain(10);

      // reset in the middle of a held transfer
      OReady = 1'b0;
      send(2'b01, 64'h3, 64'h33, 5'd9, 2'b01, 64'h33);
      send(2'b01, 64'h4, 64'h44, 5'd10, 2'b01, 64'h44);
      idle();
      #2;
      Rst_n = 1'b0;
      #1;
      chk("midrst_ovalid", {63'd0, OValid}, 64'd0);
      chk("midrst_oalu", OAlu, 64'd0);
      chk("midrst_omem", ODataMemory, 64'd0);
      chk("midrst_owb", {62'd0, OWB}, 64'd0);
      sb.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      OReady = 1'b1;
      #2;
      chk("midrst_iready", {63'd0, IReady}, 64'd1);
      send(2'b01, 64'h7, 64'h77, 5'd11, 2'b01, 64'h77);
      idle();
      drain(10);

      repeat (3) @(negedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
